// File: rtl/trap_sequencer.sv
// rtl/trap_sequencer.sv - machine-mode trap entry / mret sequencer.
// Owns the single CSR write port while a trap or return is in progress.
module trap_sequencer #(
  parameter int               XLEN        = 32,
  parameter logic [XLEN-1:0]  TIMER_CAUSE = 32'h8000_0007
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            exc_req_i,
  input  logic [XLEN-1:0] exc_cause_i,
  input  logic [XLEN-1:0] exc_tval_i,
  input  logic            mret_i,
  input  logic            irq_pending_i,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mstatus_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  output logic            stall_o,
  output logic            flush_o,
  output logic            csr_we_o,
  output logic [11:0]     csr_addr_o,
  output logic [XLEN-1:0] csr_wdata_o,
  output logic            redirect_valid_o,
  output logic [XLEN-1:0] redirect_pc_o,
  output logic            trap_taken_o,
  output logic            busy_o
);

  typedef enum logic [2:0] {
    IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SET_STATUS, TRAP_JUMP, RET_STATUS, RET_JUMP
  } state_e;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [XLEN-1:0] cause_q, cause_d;
  logic [XLEN-1:0] tval_q, tval_d;
  logic            is_irq_q, is_irq_d;

  logic            irq_take;
  logic            accept;
  logic [XLEN-1:0] trap_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] status_trap;
  logic [XLEN-1:0] status_ret;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      pc_q     <= '0;
      cause_q  <= '0;
      tval_q   <= '0;
      is_irq_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      cause_q  <= cause_d;
      tval_q   <= tval_d;
      is_irq_q <= is_irq_d;
    end
  end

  // Gating with rst keeps flush/stall quiet while reset is held.
  always_comb begin
    irq_take = irq_pending_i & mstatus_i[3];
    accept   = (state_q == IDLE) & ~rst & (exc_req_i | irq_take | mret_i);
    state_d  = state_q;
    pc_d     = pc_q;
    cause_d  = cause_q;
    tval_d   = tval_q;
    is_irq_d = is_irq_q;
    case (state_q)
      IDLE: begin
        if (exc_req_i) begin
          state_d  = SAVE_EPC;
          pc_d     = pc_i & ALIGN_MASK;
          cause_d  = exc_cause_i;
          tval_d   = exc_tval_i;
          is_irq_d = 1'b0;
        end else if (irq_take) begin
          state_d  = SAVE_EPC;
          pc_d     = pc_i & ALIGN_MASK;
          cause_d  = TIMER_CAUSE;
          tval_d   = '0;
          is_irq_d = 1'b1;
        end else if (mret_i) begin
          state_d  = RET_STATUS;
        end
      end
      SAVE_EPC:   state_d = SAVE_CAUSE;
      SAVE_CAUSE: state_d = SAVE_TVAL;
      SAVE_TVAL:  state_d = SET_STATUS;
      SET_STATUS: state_d = TRAP_JUMP;
      TRAP_JUMP:  state_d = IDLE;
      RET_STATUS: state_d = RET_JUMP;
      RET_JUMP:   state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  // Shifting the full cause drops bits 31:30, giving the mod-2^32 offset.
  always_comb begin
    trap_base   = mtvec_i & ALIGN_MASK;
    vec_off     = cause_q << 2;
    status_trap = mstatus_i;
    status_trap[7]     = mstatus_i[3];
    status_trap[3]     = 1'b0;
    status_trap[12:11] = 2'b11;
    status_ret  = mstatus_i;
    status_ret[3]      = mstatus_i[7];
    status_ret[7]      = 1'b1;
    status_ret[12:11]  = 2'b11;

    flush_o          = accept;
    stall_o          = accept | (state_q != IDLE);
    busy_o           = (state_q != IDLE);
    csr_we_o         = 1'b0;
    csr_addr_o       = 12'h000;
    csr_wdata_o      = '0;
    redirect_valid_o = 1'b0;
    redirect_pc_o    = '0;
    trap_taken_o     = 1'b0;
    case (state_q)
      SAVE_EPC: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h341;
        csr_wdata_o = pc_q;
      end
      SAVE_CAUSE: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h342;
        csr_wdata_o = cause_q;
      end
      SAVE_TVAL: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h343;
        csr_wdata_o = tval_q;
      end
      SET_STATUS: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h300;
        csr_wdata_o = status_trap;
      end
      TRAP_JUMP: begin
        redirect_valid_o = 1'b1;
        trap_taken_o     = 1'b1;
        redirect_pc_o    = (mtvec_i[1:0] == 2'b01 && is_irq_q) ? trap_base + vec_off : trap_base;
      end
      RET_STATUS: begin
        csr_we_o    = 1'b1;
        csr_addr_o  = 12'h300;
        csr_wdata_o = status_ret;
      end
      RET_JUMP: begin
        redirect_valid_o = 1'b1;
        redirect_pc_o    = mepc_i & ALIGN_MASK;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/trap_sequencer.md
# trap_sequencer

Multi-cycle controller that sequences machine-mode trap entry and `mret` return around the CSR register file. It arbitrates between synchronous exceptions, the pending machine-timer interrupt and `mret`, and stalls/flushes the core while it runs. It then drives the single CSR write port one register per cycle (mepc, mcause, mtval, mstatus) and issues the PC redirect. It sits between the core controller and the CSR unit and is the only writer of trap state.

## Interface
- `XLEN`, 32, data width.
- `TIMER_CAUSE`, 32'h8000_0007, mcause value for machine timer interrupt.
- `clk` in 1, clock.
- `rst` in 1, reset, synchronous, active-high.
- `exc_req_i` in 1, synchronous exception request from controller.
- `exc_cause_i` in 32, exception cause code (bit 31 = 0).
- `exc_tval_i` in 32, trap information (faulting address/instruction).
- `mret_i` in 1, `mret` retiring.
- `irq_pending_i` in 1, mip.MTIP & mie.MTIE.
- `pc_i` in 32, PC of faulting/next instruction.
- `mstatus_i` in 32, current mstatus.
- `mtvec_i` in 32, current mtvec.
- `mepc_i` in 32, current mepc.
- `stall_o` out 1, freeze core pipeline.
- `flush_o` out 1, kill in-flight instruction (one-cycle pulse).
- `csr_we_o` out 1, CSR write strobe.
- `csr_addr_o` out 12, CSR write address.
- `csr_wdata_o` out 32, CSR write data.
- `redirect_valid_o` out 1, load `redirect_pc_o` into PC.
- `redirect_pc_o` out 32, new PC.
- `trap_taken_o` out 1, pulse on trap-entry completion.
- `busy_o` out 1, state != IDLE.

## Operation
- States: IDLE, SAVE_EPC, SAVE_CAUSE, SAVE_TVAL, SET_STATUS, TRAP_JUMP, RET_STATUS, RET_JUMP.
- Requests sampled only in IDLE. Priority: `exc_req_i` > (`irq_pending_i` & `mstatus_i[3]`) > `mret_i`. Exceptions are taken regardless of MIE.
- On accept, latch: pc_i & ~3; cause (exc_cause_i, or TIMER_CAUSE); tval (exc_tval_i, or 0 for interrupt); an is_irq flag.
- Trap path: IDLE→SAVE_EPC (0x341 ← pc)→SAVE_CAUSE (0x342 ← cause)→SAVE_TVAL (0x343 ← tval)→SET_STATUS→TRAP_JUMP→IDLE.
- SET_STATUS writes 0x300 with mstatus_i (sampled this cycle) modified as: MPIE[7] ← MIE[3], MIE ← 0, MPP[12:11] ← 2'b11. Other bits pass through.
- TRAP_JUMP target: base = mtvec_i & ~3. If mtvec_i[1:0]==2'b01 and is_irq, target = base + (cause[30:0] << 2) (mod 2^32); otherwise target = base. Mode 2'b10/2'b11 is treated as direct.
- Return path: IDLE→RET_STATUS→RET_JUMP→IDLE. RET_STATUS writes 0x300 with MIE ← MPIE, MPIE ← 1, MPP ← 2'b11. RET_JUMP target = mepc_i & ~3, sampled that cycle.
- Requests arriving while busy are ignored. The controller holds them, since the core is stalled.
- No CSR write in IDLE or the *_JUMP states. Exactly one write per write state.

## Timing
- Reset: state IDLE. All outputs 0; latched pc/cause/tval 0. Reset mid-sequence aborts immediately with no further writes or redirect. Already-written CSRs are not rolled back.
- Accept cycle T0 (IDLE with qualifying request): `flush_o`=1 and `stall_o`=1, both combinational from the request.
- Trap: CSR writes at T1 (mepc), T2 (mcause), T3 (mtval), T4 (mstatus). At T5: `redirect_valid_o`=1 and `trap_taken_o`=1. IDLE at T6.
- Return: mstatus write at T1. At T2: `redirect_valid_o`=1. IDLE at T3.
- `stall_o`=1 from T0 through the JUMP cycle inclusive. `busy_o`=1 from T1 through the JUMP cycle.
- Outputs other than flush/stall at T0 are registered state decodes (Moore). Earliest back-to-back accept is the first IDLE cycle after a JUMP.

## Test plan
- Illegal instruction: exc_req_i=1, cause=2, pc=0x0000_0104, tval=0xDEAD_BEEF, mstatus=0x8, mtvec=0x100 → writes 0x341=0x104, 0x342=2, 0x343=0xDEADBEEF, 0x300=0x1880 on T1–T4. Redirect to 0x100 at T5; trap_taken pulses once.
- Vectored timer irq: irq_pending=1, MIE=1, mtvec=0x201, pc=0x40 → mcause=0x8000_0007, mtval=0, redirect 0x21C.
- Masked interrupt: irq_pending=1, MIE=0 → no accept, stall_o=0. Asserting exc_req_i in the same cycle → exception taken with its own cause.
- Simultaneous exc_req, irq and mret → exception sequence only. After return to IDLE with irq still pending and MIE=0 (written by SET_STATUS), no second trap.
- mret: mstatus=0x1880, mepc=0x108 → 0x300 ← 0x1888 at T1, redirect 0x108 at T2.
- Reset asserted at T2 of trap entry → IDLE next cycle, no mtval/mstatus write, no redirect. Re-request after reset is accepted normally.
